// File: rtl/n4_scan_pkg.sv
// Shared definitions for the round-robin channel scanner: FSM encoding,
// park select value and the round-robin search function.
package n4_scan_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SELECT = 2'd1,
    HOLD   = 2'd2
  } scan_state_e;

  localparam logic [7:0] SEL_PARK = 8'hFF;

  // First requesting channel after 'last', wrapping modulo n. Returns 'last' when nothing requests.
  function automatic logic [3:0] rr_next(input logic [15:0] req, input logic [3:0] last, input int n);
    logic [3:0] g;
    logic       found;
    int         idx;
    g     = last;
    found = 1'b0;
    for (int i = 1; i <= 16; i++) begin
      idx = int'(last) + i;
      if (idx >= n) idx = idx - n;
      if (!found && (i <= n) && (idx < 16) && req[idx[3:0]]) begin
        g     = idx[3:0];
        found = 1'b1;
      end
    end
    return g;
  endfunction

endpackage

// File: rtl/n4_rr_arbiter.sv
// Combinational round-robin arbiter; picks the next requester after the last grant.
module n4_rr_arbiter
  import n4_scan_pkg::*;
#(
  parameter int NUM_CH = 10
) (
  input  logic [NUM_CH-1:0] req,
  input  logic [3:0]        last,
  output logic [3:0]        grant,
  output logic              any
);

  logic [15:0] reqWide;

  assign reqWide = 16'(req);
  assign any     = |req;
  assign grant   = rr_next(reqWide, last, NUM_CH);

endmodule

// File: rtl/n4_chan_scanner.sv
// Round-robin channel scanner: drives the mux select, registers the returned
// word and hands it downstream on a valid/ready interface with a per-channel ack.
module n4_chan_scanner
#(
  parameter int         WIDTH    = 16,
  parameter int         NUM_CH   = 10,
  parameter logic [7:0] SEL_PARK = 8'hFF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  input  logic [NUM_CH-1:0] ch_req,
  output logic [7:0]        mux_select,
  input  logic [WIDTH-1:0]  mux_data,
  output logic [WIDTH-1:0]  out_data,
  output logic [3:0]        out_ch,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [NUM_CH-1:0] ch_ack,
  output logic              busy
);
  import n4_scan_pkg::*;

  scan_state_e       state_q, state_d;
  logic [7:0]        sel_q, sel_d;
  logic [WIDTH-1:0]  data_q, data_d;
  logic [3:0]        ch_q, ch_d;
  logic              valid_q, valid_d;
  logic [NUM_CH-1:0] ack_q, ack_d;
  logic [3:0]        last_q, last_d;
  logic [3:0]        grant_q, grant_d;
  logic [3:0]        arbGrant;
  logic              arbAny;

  n4_rr_arbiter #(.NUM_CH(NUM_CH)) u_arb (
    .req   (ch_req),
    .last  (last_q),
    .grant (arbGrant),
    .any   (arbAny)
  );

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    data_d  = data_q;
    ch_d    = ch_q;
    valid_d = valid_q;
    ack_d   = '0;
    last_d  = last_q;
    grant_d = grant_q;
    case (state_q)
      IDLE: begin
        if (enable && arbAny) begin
          grant_d = arbGrant;
          sel_d   = {4'h0, arbGrant};
          state_d = SELECT;
        end
      end
      SELECT: begin
        // The mux path is combinational, so the word for sel_q is present now.
        data_d  = mux_data;
        ch_d    = grant_q;
        valid_d = 1'b1;
        state_d = HOLD;
      end
      HOLD: begin
        if (out_ready) begin
          ack_d   = NUM_CH'(1) << grant_q;
          valid_d = 1'b0;
          last_d  = grant_q;
          sel_d   = SEL_PARK;
          state_d = IDLE;
        end
      end
      default: begin
        sel_d   = SEL_PARK;
        valid_d = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sel_q   <= SEL_PARK;
      data_q  <= '0;
      ch_q    <= '0;
      valid_q <= 1'b0;
      ack_q   <= '0;
      last_q  <= 4'(NUM_CH - 1);
      grant_q <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      data_q  <= data_d;
      ch_q    <= ch_d;
      valid_q <= valid_d;
      ack_q   <= ack_d;
      last_q  <= last_d;
      grant_q <= grant_d;
    end
  end

  assign mux_select = sel_q;
  assign out_data   = data_q;
  assign out_ch     = ch_q;
  assign out_valid  = valid_q;
  assign ch_ack     = ack_q;
  assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_n4_chan_scanner.sv
// Directed bench for n4_chan_scanner with behavioural 16- and 10-input muxes (in_k = 16'hA000+k).
module tb_n4_chan_scanner;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rstN16, enable16, ready16;
  logic [15:0] req16;
  logic [7:0]  sel16;
  logic [15:0] muxData16, outData16;
  logic [3:0]  outCh16;
  logic        outValid16, busy16;
  logic [15:0] ack16;

  logic        rstN10, enable10, ready10;
  logic [9:0]  req10;
  logic [7:0]  sel10;
  logic [15:0] muxData10, outData10;
  logic [3:0]  outCh10;
  logic        outValid10, busy10;
  logic [9:0]  ack10;

  int checks = 0;
  int errors = 0;

  // Mux models: in-range selects return 16'hA000+k, anything else returns 0.
  assign muxData16 = (sel16 < 8'd16) ? (16'hA000 + {8'h00, sel16}) : 16'h0000;
  assign muxData10 = (sel10 < 8'd10) ? (16'hA000 + {8'h00, sel10}) : 16'h0000;

  n4_chan_scanner #(.WIDTH(16), .NUM_CH(16), .SEL_PARK(8'hFF)) dut16 (
    .clk(clk), .rst_n(rstN16), .enable(enable16), .ch_req(req16),
    .mux_select(sel16), .mux_data(muxData16), .out_data(outData16),
    .out_ch(outCh16), .out_valid(outValid16), .out_ready(ready16),
    .ch_ack(ack16), .busy(busy16)
  );

  n4_chan_scanner #(.WIDTH(16), .NUM_CH(10), .SEL_PARK(8'hFF)) dut10 (
    .clk(clk), .rst_n(rstN10), .enable(enable10), .ch_req(req10),
    .mux_select(sel10), .mux_data(muxData10), .out_data(outData10),
    .out_ch(outCh10), .out_valid(outValid10), .out_ready(ready10),
    .ch_ack(ack10), .busy(busy10)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  task automatic stepCycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic applyStimulus(input logic [15:0] req, input logic en, input logic rdy);
    req16    = req;
    enable16 = en;
    ready16  = rdy;
  endtask

  task automatic resetDut16();
    rstN16 = 1'b0;
    stepCycle();
    stepCycle();
    rstN16 = 1'b1;
  endtask

  initial begin
    rstN16 = 1'b0; rstN10 = 1'b0;
    applyStimulus(16'h0000, 1'b0, 1'b1);
    req10 = '0; enable10 = 1'b0; ready10 = 1'b1;
    @(negedge clk);

    // 1: single requester ch0
    resetDut16();
    checkOutput("rst_valid", {31'd0, outValid16}, 32'd0);
    checkOutput("rst_sel", {24'd0, sel16}, 32'h0000_00FF);
    checkOutput("rst_busy", {31'd0, busy16}, 32'd0);
    checkOutput("rst_data", {16'd0, outData16}, 32'd0);
    applyStimulus(16'h0001, 1'b1, 1'b1);
    stepCycle();
    checkOutput("t1_sel", {24'd0, sel16}, 32'd0);
    checkOutput("t1_sel_valid", {31'd0, outValid16}, 32'd0);
    checkOutput("t1_busy", {31'd0, busy16}, 32'd1);
    stepCycle();
    checkOutput("t1_valid", {31'd0, outValid16}, 32'd1);
    checkOutput("t1_data", {16'd0, outData16}, 32'h0000_A000);
    checkOutput("t1_ch", {28'd0, outCh16}, 32'd0);
    stepCycle();
    checkOutput("t1_ack", {16'd0, ack16}, 32'h0000_0001);
    checkOutput("t1_valid_low", {31'd0, outValid16}, 32'd0);
    checkOutput("t1_park", {24'd0, sel16}, 32'h0000_00FF);
    checkOutput("t1_data_kept", {16'd0, outData16}, 32'h0000_A000);
    applyStimulus(16'h0000, 1'b1, 1'b1);
    stepCycle();
    checkOutput("t1_ack_pulse", {16'd0, ack16}, 32'd0);

    // 2: all channels requesting, order 0..15 then wrap to 0
    resetDut16();
    applyStimulus(16'hFFFF, 1'b1, 1'b1);
    for (int k = 0; k < 17; k++) begin
      stepCycle();
      checkOutput("t2_sel", {24'd0, sel16}, 32'(k % 16));
      stepCycle();
      checkOutput("t2_ch", {28'd0, outCh16}, 32'(k % 16));
      checkOutput("t2_data", {16'd0, outData16}, 32'h0000_A000 + 32'(k % 16));
      checkOutput("t2_hold_noack", {16'd0, ack16}, 32'd0);
      stepCycle();
      checkOutput("t2_ack", {16'd0, ack16}, 32'd1 << (k % 16));
    end
    applyStimulus(16'h0000, 1'b1, 1'b1);
    stepCycle();

    // 3: back-pressure in HOLD; last grant is 0, so ch2 first, then ch5
    applyStimulus(16'h0024, 1'b1, 1'b0);
    stepCycle();
    checkOutput("t3_sel", {24'd0, sel16}, 32'd2);
    stepCycle();
    for (int c = 0; c < 5; c++) begin
      checkOutput("t3_hold_data", {16'd0, outData16}, 32'h0000_A002);
      checkOutput("t3_hold_sel", {24'd0, sel16}, 32'd2);
      checkOutput("t3_hold_valid", {31'd0, outValid16}, 32'd1);
      checkOutput("t3_hold_noack", {16'd0, ack16}, 32'd0);
      stepCycle();
    end
    ready16 = 1'b1;
    stepCycle();
    checkOutput("t3_ack2", {16'd0, ack16}, 32'h0000_0004);
    applyStimulus(16'h0020, 1'b1, 1'b1);
    stepCycle();
    checkOutput("t3_sel5", {24'd0, sel16}, 32'd5);
    stepCycle();
    checkOutput("t3_ch5", {28'd0, outCh16}, 32'd5);
    checkOutput("t3_data5", {16'd0, outData16}, 32'h0000_A005);
    stepCycle();
    checkOutput("t3_ack5", {16'd0, ack16}, 32'h0000_0020);
    applyStimulus(16'h0000, 1'b1, 1'b1);

    // 4: enable low keeps the scanner parked
    applyStimulus(16'hFFFF, 1'b0, 1'b1);
    resetDut16();
    for (int c = 0; c < 3; c++) begin
      stepCycle();
      checkOutput("t4_park", {24'd0, sel16}, 32'h0000_00FF);
      checkOutput("t4_busy", {31'd0, busy16}, 32'd0);
    end
    applyStimulus(16'hFFFF, 1'b1, 1'b0);
    stepCycle();
    checkOutput("t4_first", {24'd0, sel16}, 32'd0);
    stepCycle();
    checkOutput("t4_hold_ch", {28'd0, outCh16}, 32'd0);
    checkOutput("t4_hold_valid", {31'd0, outValid16}, 32'd1);

    // 5: reset while in HOLD drops the word
    rstN16 = 1'b0;
    stepCycle();
    checkOutput("t5_valid", {31'd0, outValid16}, 32'd0);
    checkOutput("t5_park", {24'd0, sel16}, 32'h0000_00FF);
    checkOutput("t5_noack", {16'd0, ack16}, 32'd0);
    checkOutput("t5_busy", {31'd0, busy16}, 32'd0);
    rstN16 = 1'b1;
    applyStimulus(16'hFFFF, 1'b1, 1'b1);
    stepCycle();
    checkOutput("t5_regrant", {24'd0, sel16}, 32'd0);
    stepCycle();
    stepCycle();
    checkOutput("t5_ack_after", {16'd0, ack16}, 32'h0000_0001);
    applyStimulus(16'h0000, 1'b1, 1'b1);

    // 6: ten-channel instance, ch9 then wrap to ch0
    rstN10 = 1'b1;
    req10 = 10'h200; enable10 = 1'b1; ready10 = 1'b1;
    stepCycle();
    checkOutput("t6_sel9", {24'd0, sel10}, 32'd9);
    stepCycle();
    checkOutput("t6_ch9", {28'd0, outCh10}, 32'd9);
    checkOutput("t6_data9", {16'd0, outData10}, 32'h0000_A009);
    stepCycle();
    checkOutput("t6_ack9", {22'd0, ack10}, 32'h0000_0200);
    req10 = 10'h201;
    stepCycle();
    checkOutput("t6_wrap_sel", {24'd0, sel10}, 32'd0);
    stepCycle();
    checkOutput("t6_wrap_ch", {28'd0, outCh10}, 32'd0);
    checkOutput("t6_wrap_data", {16'd0, outData10}, 32'h0000_A000);
    stepCycle();
    checkOutput("t6_wrap_ack", {22'd0, ack10}, 32'h0000_0001);
    req10 = 10'h000;
    stepCycle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
